// File: rtl/cube_pkg.sv
// Shared types, cube topology and helpers for the cube edge sequencer.
package cube_pkg;

    localparam int unsigned VTX_XW = 11;
    localparam int unsigned VTX_YW = 10;
    localparam int unsigned N_VTX  = 8;
    localparam int unsigned N_EDGE = 12;
    localparam int unsigned VW     = $clog2(N_VTX);
    localparam int unsigned EW     = $clog2(N_EDGE);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_LOAD,
        S_START,
        S_WAIT,
        S_NEXT,
        S_FIN
    } seq_state_t;

    typedef struct packed {
        logic [VTX_XW-1:0] x;
        logic [VTX_YW-1:0] y;
    } vertex_t;

    // Front face 0-3, back face 4-7, then the four front-to-back struts.
    localparam logic [VW-1:0] EDGE_A [N_EDGE] = '{
        3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2, 3'd3
    };
    localparam logic [VW-1:0] EDGE_B [N_EDGE] = '{
        3'd1, 3'd2, 3'd3, 3'd0, 3'd5, 3'd6, 3'd7, 3'd4, 3'd4, 3'd5, 3'd6, 3'd7
    };

    function automatic logic is_last_edge(input logic [EW-1:0] e);
        return e == EW'(N_EDGE - 1);
    endfunction

endpackage

// File: rtl/cube_edge_sequencer_if.sv
// Host vertex/commit inputs, line-engine handshake and status of the cube edge sequencer.
interface cube_edge_sequencer_if #(
    parameter int unsigned XW = cube_pkg::VTX_XW,
    parameter int unsigned YW = cube_pkg::VTX_YW
);

    logic                        en;
    logic                        frame_sync;
    logic                        vtx_we;
    logic [cube_pkg::VW-1:0]     vtx_addr;
    logic [XW-1:0]               vtx_x;
    logic [YW-1:0]               vtx_y;
    logic [cube_pkg::N_EDGE-1:0] edge_mask;
    logic                        line_done;

    logic                        line_start;
    logic [XW-1:0]               line_x0;
    logic [YW-1:0]               line_y0;
    logic [XW-1:0]               line_x1;
    logic [YW-1:0]               line_y1;
    logic [cube_pkg::EW-1:0]     edge_idx;
    logic                        busy;
    logic                        frame_done;
    logic                        timeout_err;

    modport master (
        output en, frame_sync, vtx_we, vtx_addr, vtx_x, vtx_y, edge_mask, line_done,
        input  line_start, line_x0, line_y0, line_x1, line_y1, edge_idx,
        input  busy, frame_done, timeout_err
    );

    modport slave (
        input  en, frame_sync, vtx_we, vtx_addr, vtx_x, vtx_y, edge_mask, line_done,
        output line_start, line_x0, line_y0, line_x1, line_y1, edge_idx,
        output busy, frame_done, timeout_err
    );

endinterface

// File: rtl/cube_vertex_bank.sv
// Double-buffered vertex table: host writes land in the shadow copy, commit copies shadow to active.
module cube_vertex_bank
    import cube_pkg::*;
#(
    parameter int unsigned XW = VTX_XW,
    parameter int unsigned YW = VTX_YW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [VW-1:0] wr_addr,
    input  logic [XW-1:0] wr_x,
    input  logic [YW-1:0] wr_y,
    input  logic          commit,
    input  logic [VW-1:0] rd_a_addr,
    input  logic [VW-1:0] rd_b_addr,
    output logic [XW-1:0] rd_a_x_c,
    output logic [YW-1:0] rd_a_y_c,
    output logic [XW-1:0] rd_b_x_c,
    output logic [YW-1:0] rd_b_y_c
);

    localparam int unsigned DW = XW + YW;

    logic [DW-1:0] shadow_q [N_VTX];
    logic [DW-1:0] shadow_d [N_VTX];
    logic [DW-1:0] active_q [N_VTX];
    logic [DW-1:0] active_d [N_VTX];

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en) begin
            shadow_d[wr_addr] = {wr_x, wr_y};
        end
    end

    // Copy from shadow_d so a write in the commit cycle reaches the active table too.
    always_comb begin
        active_d = active_q;
        if (commit) begin
            active_d = shadow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(N_VTX); i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
        end
    end

    assign {rd_a_x_c, rd_a_y_c} = active_q[rd_a_addr];
    assign {rd_b_x_c, rd_b_y_c} = active_q[rd_b_addr];

endmodule

// File: rtl/cube_edge_sequencer.sv
// Walks the line engine through the 12 cube edges once per committed frame,
// skipping masked edges and abandoning any edge whose line_done never arrives.
module cube_edge_sequencer
    import cube_pkg::*;
#(
    parameter int unsigned XW      = VTX_XW,
    parameter int unsigned YW      = VTX_YW,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                  iCLK,
    input  logic                  iRST_n,
    cube_edge_sequencer_if.slave  bus
);

    localparam int unsigned CW = $clog2(TIMEOUT);

    seq_state_t          state_q,       state_d;
    logic [EW-1:0]       edge_idx_q,    edge_idx_d;
    logic [N_EDGE-1:0]   mask_q,        mask_d;
    logic [CW-1:0]       wait_cnt_q,    wait_cnt_d;
    logic                line_start_q,  line_start_d;
    logic [XW-1:0]       line_x0_q,     line_x0_d;
    logic [YW-1:0]       line_y0_q,     line_y0_d;
    logic [XW-1:0]       line_x1_q,     line_x1_d;
    logic [YW-1:0]       line_y1_q,     line_y1_d;
    logic                busy_q,        busy_d;
    logic                frame_done_q,  frame_done_d;
    logic                timeout_err_q, timeout_err_d;

    logic                commit_c;
    logic [VW-1:0]       vtx_a_c;
    logic [VW-1:0]       vtx_b_c;
    logic [XW-1:0]       rd_a_x_c;
    logic [YW-1:0]       rd_a_y_c;
    logic [XW-1:0]       rd_b_x_c;
    logic [YW-1:0]       rd_b_y_c;

    assign vtx_a_c = EDGE_A[edge_idx_q];
    assign vtx_b_c = EDGE_B[edge_idx_q];

    cube_vertex_bank #(
        .XW (XW),
        .YW (YW)
    ) u_bank (
        .clk       (iCLK),
        .rst_n     (iRST_n),
        .wr_en     (bus.vtx_we),
        .wr_addr   (bus.vtx_addr),
        .wr_x      (bus.vtx_x),
        .wr_y      (bus.vtx_y),
        .commit    (commit_c),
        .rd_a_addr (vtx_a_c),
        .rd_b_addr (vtx_b_c),
        .rd_a_x_c  (rd_a_x_c),
        .rd_a_y_c  (rd_a_y_c),
        .rd_b_x_c  (rd_b_x_c),
        .rd_b_y_c  (rd_b_y_c)
    );

    always_comb begin
        state_d       = state_q;
        edge_idx_d    = edge_idx_q;
        mask_d        = mask_q;
        wait_cnt_d    = wait_cnt_q;
        line_start_d  = 1'b0;
        line_x0_d     = line_x0_q;
        line_y0_d     = line_y0_q;
        line_x1_d     = line_x1_q;
        line_y1_d     = line_y1_q;
        busy_d        = busy_q;
        frame_done_d  = 1'b0;
        timeout_err_d = timeout_err_q;
        commit_c      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.en && bus.frame_sync) begin
                    commit_c      = 1'b1;
                    mask_d        = bus.edge_mask;
                    timeout_err_d = 1'b0;
                    busy_d        = 1'b1;
                    edge_idx_d    = '0;
                    state_d       = S_SCAN;
                end
            end
            S_SCAN: begin
                if (mask_q[edge_idx_q]) begin
                    state_d = S_LOAD;
                end else if (is_last_edge(edge_idx_q)) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = S_FIN;
                end else begin
                    edge_idx_d = edge_idx_q + EW'(1);
                end
            end
            S_LOAD: begin
                line_x0_d    = rd_a_x_c;
                line_y0_d    = rd_a_y_c;
                line_x1_d    = rd_b_x_c;
                line_y1_d    = rd_b_y_c;
                line_start_d = 1'b1;
                state_d      = S_START;
            end
            S_START: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            // Count 0 marks the entry cycle, where a done still high from the last line is ignored.
            S_WAIT: begin
                if (bus.line_done && (wait_cnt_q != '0)) begin
                    state_d = S_NEXT;
                end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = S_NEXT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            S_NEXT: begin
                if (is_last_edge(edge_idx_q)) begin
                    frame_done_d = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = S_FIN;
                end else begin
                    edge_idx_d = edge_idx_q + EW'(1);
                    state_d    = S_SCAN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state_q       <= S_IDLE;
            edge_idx_q    <= '0;
            mask_q        <= '0;
            wait_cnt_q    <= '0;
            line_start_q  <= 1'b0;
            line_x0_q     <= '0;
            line_y0_q     <= '0;
            line_x1_q     <= '0;
            line_y1_q     <= '0;
            busy_q        <= 1'b0;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            edge_idx_q    <= edge_idx_d;
            mask_q        <= mask_d;
            wait_cnt_q    <= wait_cnt_d;
            line_start_q  <= line_start_d;
            line_x0_q     <= line_x0_d;
            line_y0_q     <= line_y0_d;
            line_x1_q     <= line_x1_d;
            line_y1_q     <= line_y1_d;
            busy_q        <= busy_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus.line_start  = line_start_q;
    assign bus.line_x0     = line_x0_q;
    assign bus.line_y0     = line_y0_q;
    assign bus.line_x1     = line_x1_q;
    assign bus.line_y1     = line_y1_q;
    assign bus.edge_idx    = edge_idx_q;
    assign bus.busy        = busy_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.timeout_err = timeout_err_q;

endmodule
